vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 112 +++++++++++
 tb/tb_vga_sync_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal/vertical pixel counters with registered
// sync, blanking and line/frame start strobes, all aligned to the same edge.
module vga_sync_gen #(
   parameter int unsigned H_VIS  = 640,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 96,
   parameter int unsigned H_BP   = 48,
   parameter int unsigned V_VIS  = 480,
   parameter int unsigned V_FP   = 10,
   parameter int unsigned V_SYNC = 2,
   parameter int unsigned V_BP   = 33
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       en,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned CW    = 10;
   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
   localparam logic [CW-1:0] H_VIS_END  = CW'(H_VIS);
   localparam logic [CW-1:0] V_VIS_END  = CW'(V_VIS);
   localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_VIS + H_FP);
   localparam logic [CW-1:0] H_SYNC_END = CW'(H_VIS + H_FP + H_SYNC);
   localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_VIS + V_FP);
   localparam logic [CW-1:0] V_SYNC_END = CW'(V_VIS + V_FP + V_SYNC);

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic [CW-1:0] h_nxt;
   logic [CW-1:0] v_nxt;
   logic          hsync_nxt;
   logic          vsync_nxt;
   logic          video_on_nxt;
   logic          line_start_nxt;
   logic          frame_start_nxt;

   // Next counter pair: h wraps at end of line, v advances only on that wrap.
   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         if (v_cnt == V_LAST) begin
            v_nxt = '0;
         end else begin
            v_nxt = v_cnt + CW'(1);
         end
      end else begin
         h_nxt = h_cnt + CW'(1);
      end
   end

   // Decode from the next pair so registered outputs line up with the counters.
   always_comb begin
      hsync_nxt       = 1'b1;
      vsync_nxt       = 1'b1;
      video_on_nxt    = 1'b0;
      line_start_nxt  = 1'b0;
      frame_start_nxt = 1'b0;
      if ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) begin
         hsync_nxt = 1'b0;
      end
      if ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) begin
         vsync_nxt = 1'b0;
      end
      if ((h_nxt < H_VIS_END) && (v_nxt < V_VIS_END)) begin
         video_on_nxt = 1'b1;
      end
      if (h_nxt == '0) begin
         line_start_nxt = 1'b1;
         if (v_nxt == '0) begin
            frame_start_nxt = 1'b1;
         end
      end
   end

   // Reset lands on (0,0) with outputs already decoded for that position.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b1;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else if (en) begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         hsync       <= hsync_nxt;
         vsync       <= vsync_nxt;
         video_on    <= video_on_nxt;
         line_start  <= line_start_nxt;
         frame_start <= frame_start_nxt;
      end
   end

   assign pixel_x = h_cnt;
   assign pixel_y = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size 640x480 instance for line timing, a reduced-size
// instance (16x12 totals) for frame-level timing that fits a short run.
module tb_vga_sync_gen;

   logic       clk = 1'b0;
   logic       rst_a, en_a, rst_b, en_b;
   logic       a_hs, a_vs, a_vo, a_ls, a_fs;
   logic       b_hs, b_vs, b_vo, b_ls, b_fs;
   logic [9:0] a_px, a_py, b_px, b_py;
   logic       arm_a = 1'b0;
   logic       arm_b = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   vga_sync_gen dut_a (
      .clk_in(clk), .reset(rst_a), .en(en_a),
      .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
      .pixel_x(a_px), .pixel_y(a_py),
      .line_start(a_ls), .frame_start(a_fs)
   );

   // Small timing: h sync 10..12, h total 16; v sync 8..9, v total 12.
   vga_sync_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_b (
      .clk_in(clk), .reset(rst_b), .en(en_b),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
      .pixel_x(b_px), .pixel_y(b_py),
      .line_start(b_ls), .frame_start(b_fs)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every cycle, outputs must match an independent decode of the reported position.
   always @(negedge clk) begin
      if (arm_a) begin
         check("a_bounds", {30'd0, a_px < 10'd800, a_py < 10'd525}, 32'd3);
         check("a_decode", {27'd0, a_hs, a_vs, a_vo, a_ls, a_fs},
               {27'd0, !(a_px >= 10'd656 && a_px < 10'd752),
                       !(a_py >= 10'd490 && a_py < 10'd492),
                       (a_px < 10'd640 && a_py < 10'd480),
                       (a_px == 10'd0),
                       (a_px == 10'd0 && a_py == 10'd0)});
      end
      if (arm_b) begin
         check("b_bounds", {30'd0, b_px < 10'd16, b_py < 10'd12}, 32'd3);
         check("b_decode", {27'd0, b_hs, b_vs, b_vo, b_ls, b_fs},
               {27'd0, !(b_px >= 10'd10 && b_px < 10'd13),
                       !(b_py >= 10'd8 && b_py < 10'd10),
                       (b_px < 10'd8 && b_py < 10'd6),
                       (b_px == 10'd0),
                       (b_px == 10'd0 && b_py == 10'd0)});
      end
   end

   initial begin
      int n;
      int hs_lo, vs_lo, vo_n, fs_n, fs_at;
      rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
      #1;
      tick(2);

      // Reset with en low still initialises both instances.
      check("a_rst_xy",   {12'd0, a_px, a_py}, 32'd0);
      check("a_rst_outs", {27'd0, a_hs, a_vs, a_vo, a_ls, a_fs}, 32'h1F);
      check("b_rst_xy",   {12'd0, b_px, b_py}, 32'd0);
      check("b_rst_outs", {27'd0, b_hs, b_vs, b_vo, b_ls, b_fs}, 32'h1F);
      arm_a = 1'b1; arm_b = 1'b1;

      // First enabled edge after reset.
      rst_a = 1'b0; en_a = 1'b1;
      tick(1);
      check("a_first_x",  a_px, 32'd1);
      check("a_first_y",  a_py, 32'd0);
      check("a_first_ls", a_ls, 32'd0);
      check("a_first_fs", a_fs, 32'd0);

      // Visible edge (639,0)->(640,0).
      tick(638);
      check("a_x639",    a_px, 32'd639);
      check("a_vo_639",  a_vo, 32'd1);
      tick(1);
      check("a_x640",    a_px, 32'd640);
      check("a_vo_640",  a_vo, 32'd0);

      // Freeze 5 cycles at 655, then hsync falls on the first enabled edge.
      tick(15);
      check("a_x655", a_px, 32'd655);
      en_a = 1'b0;
      tick(5);
      check("a_hold_x",  a_px, 32'd655);
      check("a_hold_hs", a_hs, 32'd1);
      en_a = 1'b1;
      tick(1);
      check("a_x656",    a_px, 32'd656);
      check("a_hs_fall", a_hs, 32'd0);

      n = 0;
      while (a_hs === 1'b0 && n < 200) begin
         tick(1);
         n++;
      end
      check("a_hs_width", n, 32'd96);
      check("a_hs_end_x", a_px, 32'd752);

      // Line wrap (799,0)->(0,1), then line_start period.
      tick(47);
      check("a_x799", {12'd0, a_px, a_py}, {12'd0, 10'd799, 10'd0});
      tick(1);
      check("a_wrap_xy", {12'd0, a_px, a_py}, {12'd0, 10'd0, 10'd1});
      check("a_wrap_ls", a_ls, 32'd1);
      check("a_wrap_fs", a_fs, 32'd0);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (a_ls !== 1'b1 && n < 2000);
      check("a_line_period", n, 32'd800);
      check("a_line_y",      a_py, 32'd2);

      // Reset in the middle of hsync.
      tick(700);
      check("a_x700_hs", {21'd0, a_px, a_hs}, {21'd0, 10'd700, 1'b0});
      rst_a = 1'b1;
      tick(1);
      check("a_mrst_xy",   {12'd0, a_px, a_py}, 32'd0);
      check("a_mrst_outs", {27'd0, a_hs, a_vs, a_vo, a_ls, a_fs}, 32'h1F);
      rst_a = 1'b0;
      tick(1);
      check("a_mrst_next", {11'd0, a_px, a_py, a_fs}, {11'd0, 10'd1, 10'd0, 1'b0});
      en_a = 1'b0;

      // Small instance: one full frame from (0,0).
      rst_b = 1'b0; en_b = 1'b1;
      hs_lo = 0; vs_lo = 0; vo_n = 0; fs_n = 0; fs_at = -1;
      for (int i = 0; i < 192; i++) begin
         tick(1);
         if (b_hs === 1'b0) hs_lo++;
         if (b_vs === 1'b0) vs_lo++;
         if (b_vo === 1'b1) vo_n++;
         if (b_fs === 1'b1) begin
            fs_n++;
            fs_at = i;
         end
      end
      check("b_hs_cycles",  hs_lo, 32'd36);
      check("b_vs_cycles",  vs_lo, 32'd32);
      check("b_vo_cycles",  vo_n,  32'd48);
      check("b_fs_count",   fs_n,  32'd1);
      check("b_fs_period",  fs_at, 32'd191);
      check("b_frame_xy",   {12'd0, b_px, b_py}, 32'd0);

      // (15,5)->(0,6) stays blank; (15,11)->(0,0) raises frame_start.
      tick(95);
      check("b_x15y5",   {11'd0, b_px, b_py, b_vo}, {11'd0, 10'd15, 10'd5, 1'b0});
      tick(1);
      check("b_x0y6",    {10'd0, b_px, b_py, b_vo, b_ls}, {10'd0, 10'd0, 10'd6, 1'b0, 1'b1});
      tick(95);
      check("b_x15y11",  {11'd0, b_px, b_py, b_fs}, {11'd0, 10'd15, 10'd11, 1'b0});
      tick(1);
      check("b_fwrap",   {10'd0, b_px, b_py, b_fs, b_vo}, {10'd0, 10'd0, 10'd0, 1'b1, 1'b1});

      // Reset while both syncs are active.
      tick(155);
      check("b_x11y9",   {10'd0, b_px, b_py, b_hs, b_vs}, {10'd0, 10'd11, 10'd9, 1'b0, 1'b0});
      rst_b = 1'b1;
      tick(1);
      check("b_rst2_xy",   {12'd0, b_px, b_py}, 32'd0);
      check("b_rst2_outs", {27'd0, b_hs, b_vs, b_vo, b_ls, b_fs}, 32'h1F);
      rst_b = 1'b0;
      tick(1);
      check("b_rst2_next", {11'd0, b_px, b_py, b_fs}, {11'd0, 10'd1, 10'd0, 1'b0});

      // Reset wins over en low.
      en_b = 1'b0; rst_b = 1'b1;
      tick(1);
      check("b_rst_en0", {11'd0, b_px, b_py, b_fs}, {11'd0, 10'd0, 10'd0, 1'b1});
      rst_b = 1'b0;
      tick(1);
      check("b_hold_rst", {11'd0, b_px, b_py, b_fs}, {11'd0, 10'd0, 10'd0, 1'b1});

      @(negedge clk);
      arm_a = 1'b0; arm_b = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
